// File: rtl/choose_cursor_pkg.sv
// Shared definitions for the choose scene: slot numbering, grid shape, state encoding
// and the cursor step helper.
package choose_cursor_pkg;

  localparam logic [7:0] SLOT_MIN  = 8'd1;
  localparam logic [7:0] SLOT_MAX  = 8'd8;
  localparam int         GRID_COLS = 4;
  localparam int         GRID_ROWS = 2;
  localparam int         COL_W     = $clog2(GRID_COLS);

  // One-hot direction vector layout; the lowest set bit has the highest priority.
  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BROWSE = 2'd1,
    ST_LOCKED = 2'd2
  } choose_state_t;

  // Moves the cursor one step. Left and right wrap inside the row.
  // Up and down flip the row and keep the column.
  function automatic logic [7:0] next_slot(input logic [7:0] id, input logic [3:0] dir);
    logic [7:0]       idx;
    logic [COL_W-1:0] col;
    logic             row;
    idx = id - SLOT_MIN;
    col = idx[COL_W-1:0];
    row = idx[COL_W];
    if (dir[DIR_LEFT])
      col = col - 1'b1;
    else if (dir[DIR_RIGHT])
      col = col + 1'b1;
    else if (dir[DIR_UP] || dir[DIR_DOWN])
      row = ~row;
    return 8'({row, col}) + SLOT_MIN;
  endfunction

endpackage

// File: rtl/choose_cursor_ctrl_btn_repeat.sv
// Direction edge detect with priority pick and hold-to-repeat.
// Emits a one-cycle step pulse with the one-hot direction that produced it.
module btn_repeat
  import choose_cursor_pkg::*;
#(
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic [3:0] lvl,
  output logic       step,
  output logic [3:0] step_dir
);

  localparam int MAX_CNT = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PER);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [3:0]       prev;
  logic [3:0]       edges;
  logic [3:0]       win;
  logic [3:0]       track;
  logic [CNT_W-1:0] cnt;
  logic             rep_phase;
  logic             held;
  logic             rep_hit;

  assign edges   = lvl & ~prev;
  assign win     = edges & (~edges + 4'd1);
  assign held    = |(lvl & track);
  // cnt equals the number of cycles since the last step of the tracked direction.
  assign rep_hit = held && (cnt == (rep_phase ? PER_C : DLY_C));

  always_comb begin
    step     = 1'b0;
    step_dir = 4'd0;
    if (active) begin
      if (|win) begin
        step     = 1'b1;
        step_dir = win;
      end else if (rep_hit) begin
        step     = 1'b1;
        step_dir = track;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= 4'd0;
      track     <= 4'd0;
      cnt       <= '0;
      rep_phase <= 1'b0;
    end else begin
      prev <= lvl;
      if (!active || (!(|win) && !held)) begin
        track     <= 4'd0;
        cnt       <= '0;
        rep_phase <= 1'b0;
      end else if (|win) begin
        track     <= win;
        cnt       <= ONE_C;
        rep_phase <= 1'b0;
      end else if (rep_hit) begin
        cnt       <= ONE_C;
        rep_phase <= 1'b1;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/choose_cursor_ctrl.sv
// Cursor and selection controller for the choose scene: browse the 2x4 grid,
// confirm a slot, hand the chosen id downstream with a valid/ack handshake.
//
// state      | meaning
// ST_IDLE    | scene inactive, edges ignored
// ST_BROWSE  | cursor moves on direction steps
// ST_LOCKED  | selection confirmed, cursor frozen
module choose_cursor_ctrl
  import choose_cursor_pkg::*;
#(
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  input  logic       choose_ack,
  output logic [7:0] pokemon_id,
  output logic       locked,
  output logic       choose_valid,
  output logic [7:0] chosen_id
);

  choose_state_t state, state_nxt;
  logic [7:0]    id_nxt, chosen_nxt;
  logic          locked_nxt, valid_nxt;
  logic          prev_confirm, prev_cancel;
  logic          confirm_edge, cancel_edge;
  logic          step;
  logic [3:0]    step_dir;

  assign confirm_edge = btn_confirm & ~prev_confirm;
  assign cancel_edge  = btn_cancel & ~prev_cancel;

  btn_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_btn_repeat (
    .clk     (clk),
    .rst     (rst),
    .active  (enable && (state == ST_BROWSE)),
    .lvl     ({btn_down, btn_up, btn_right, btn_left}),
    .step    (step),
    .step_dir(step_dir)
  );

  always_comb begin
    state_nxt  = state;
    id_nxt     = pokemon_id;
    chosen_nxt = chosen_id;
    locked_nxt = locked;
    valid_nxt  = choose_valid;
    if (!enable) begin
      state_nxt  = ST_IDLE;
      locked_nxt = 1'b0;
      valid_nxt  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_BROWSE;
        ST_BROWSE: begin
          // Confirm takes precedence; a same-cycle move is dropped.
          if (confirm_edge) begin
            state_nxt  = ST_LOCKED;
            chosen_nxt = pokemon_id;
            locked_nxt = 1'b1;
            valid_nxt  = 1'b1;
          end else if (step) begin
            id_nxt = next_slot(pokemon_id, step_dir);
          end
        end
        ST_LOCKED: begin
          if (cancel_edge) begin
            state_nxt  = ST_BROWSE;
            locked_nxt = 1'b0;
            valid_nxt  = 1'b0;
          end else if (choose_ack) begin
            valid_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt  = ST_IDLE;
          locked_nxt = 1'b0;
          valid_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      pokemon_id   <= SLOT_MIN;
      chosen_id    <= 8'd0;
      locked       <= 1'b0;
      choose_valid <= 1'b0;
      prev_confirm <= 1'b0;
      prev_cancel  <= 1'b0;
    end else begin
      state        <= state_nxt;
      pokemon_id   <= id_nxt;
      chosen_id    <= chosen_nxt;
      locked       <= locked_nxt;
      choose_valid <= valid_nxt;
      prev_confirm <= btn_confirm;
      prev_cancel  <= btn_cancel;
    end
  end

endmodule

// File: tb/tb_choose_cursor_ctrl.sv
// Directed bench for choose_cursor_ctrl with short repeat timing; expectations are
// queued as each step is driven and compared once the clock edge has been taken.
module tb_choose_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       btn_confirm = 1'b0, btn_cancel = 1'b0, choose_ack = 1'b0;
  logic [7:0] pokemon_id, chosen_id;
  logic       locked, choose_valid;

  typedef struct {
    string      tag;
    logic [7:0] id;
    logic       lk;
    logic       vd;
    logic [7:0] ch;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  choose_cursor_ctrl #(.REPEAT_DLY(5), .REPEAT_PER(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_confirm(btn_confirm), .btn_cancel(btn_cancel), .choose_ack(choose_ack),
    .pokemon_id(pokemon_id), .locked(locked), .choose_valid(choose_valid),
    .chosen_id(chosen_id)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [7:0] id, input logic lk,
                      input logic vd, input logic [7:0] ch);
    exp_t e;
    e.tag = tag; e.id = id; e.lk = lk; e.vd = vd; e.ch = ch;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = q.pop_front();
    checks++;
    assert (pokemon_id === e.id) else begin
      errors++;
      $error("FAIL %s pokemon_id observed=%0d expected=%0d", e.tag, pokemon_id, e.id);
    end
    checks++;
    assert (locked === e.lk) else begin
      errors++;
      $error("FAIL %s locked observed=%0b expected=%0b", e.tag, locked, e.lk);
    end
    checks++;
    assert (choose_valid === e.vd) else begin
      errors++;
      $error("FAIL %s choose_valid observed=%0b expected=%0b", e.tag, choose_valid, e.vd);
    end
    checks++;
    assert (chosen_id === e.ch) else begin
      errors++;
      $error("FAIL %s chosen_id observed=%0d expected=%0d", e.tag, chosen_id, e.ch);
    end
  endtask

  // One clock with the inputs as currently driven, then compare.
  task automatic cyc(input string tag, input logic [7:0] id, input logic lk,
                     input logic vd, input logic [7:0] ch);
    push(tag, id, lk, vd, ch);
    @(posedge clk);
    #1;
    check();
  endtask

  // Press a direction mask for one cycle, then release for one cycle (browsing, unlocked).
  task automatic pulse(input logic [3:0] d, input string tag, input logic [7:0] id,
                       input logic [7:0] ch);
    {btn_down, btn_up, btn_right, btn_left} = d;
    cyc(tag, id, 1'b0, 1'b0, ch);
    {btn_down, btn_up, btn_right, btn_left} = 4'b0000;
    cyc({tag, "_rel"}, id, 1'b0, 1'b0, ch);
  endtask

  localparam logic [3:0] L = 4'b0001, R = 4'b0010, U = 4'b0100, D = 4'b1000;

  initial begin
    logic [7:0] hold_exp [10];

    #2 rst = 1'b1;
    #1;
    push("reset", 8'd1, 1'b0, 1'b0, 8'd0);
    check();
    @(posedge clk); #1;
    rst = 1'b0;

    enable = 1'b1;
    cyc("enter_browse", 8'd1, 1'b0, 1'b0, 8'd0);

    // Row 0 walk and wrap.
    pulse(R, "right1", 8'd2, 8'd0);
    pulse(R, "right2", 8'd3, 8'd0);
    pulse(R, "right3", 8'd4, 8'd0);
    pulse(R, "right_wrap", 8'd1, 8'd0);

    // Row toggles and left wrap in row 1.
    pulse(R, "to3a", 8'd2, 8'd0);
    pulse(R, "to3b", 8'd3, 8'd0);
    pulse(D, "down3", 8'd7, 8'd0);
    pulse(U, "up7", 8'd3, 8'd0);
    pulse(D, "down3b", 8'd7, 8'd0);
    pulse(L, "left7", 8'd6, 8'd0);
    pulse(L, "left6", 8'd5, 8'd0);
    pulse(L, "left_wrap5", 8'd8, 8'd0);

    // Left beats up when pressed together.
    pulse(L | U, "prio_left_up", 8'd7, 8'd0);
    pulse(R | D, "prio_right_down", 8'd8, 8'd0);

    // Back to id 1 for the hold test.
    pulse(U, "up8", 8'd4, 8'd0);
    pulse(R, "right4", 8'd1, 8'd0);

    // Hold right 10 cycles: steps at press, +5, +7, +9. Four steps in a 4-wide row
    // bring the cursor back round to 1.
    hold_exp = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd1};
    btn_right = 1'b1;
    for (int k = 0; k < 10; k++)
      cyc($sformatf("hold_k%0d", k), hold_exp[k], 1'b0, 1'b0, 8'd0);
    btn_right = 1'b0;
    cyc("hold_release", 8'd1, 1'b0, 1'b0, 8'd0);

    // Confirm together with a left press at id 6.
    pulse(D, "down1", 8'd5, 8'd0);
    pulse(R, "right5", 8'd6, 8'd0);
    btn_confirm = 1'b1; btn_left = 1'b1;
    cyc("confirm_left", 8'd6, 1'b1, 1'b1, 8'd6);
    btn_confirm = 1'b0; btn_left = 1'b0;
    cyc("locked_wait1", 8'd6, 1'b1, 1'b1, 8'd6);
    btn_right = 1'b1;
    cyc("locked_ignore_dir", 8'd6, 1'b1, 1'b1, 8'd6);
    btn_right = 1'b0;
    choose_ack = 1'b1;
    cyc("ack_drop", 8'd6, 1'b1, 1'b0, 8'd6);
    choose_ack = 1'b0;
    cyc("after_ack", 8'd6, 1'b1, 1'b0, 8'd6);

    // Cancel back to browse, move to 2, lock, then cancel with a same-cycle ack.
    btn_cancel = 1'b1;
    cyc("cancel", 8'd6, 1'b0, 1'b0, 8'd6);
    btn_cancel = 1'b0;
    cyc("cancel_rel", 8'd6, 1'b0, 1'b0, 8'd6);
    pulse(U, "up6", 8'd2, 8'd6);
    btn_confirm = 1'b1;
    cyc("confirm2", 8'd2, 1'b1, 1'b1, 8'd2);
    btn_confirm = 1'b0;
    cyc("confirm2_rel", 8'd2, 1'b1, 1'b1, 8'd2);
    btn_cancel = 1'b1; choose_ack = 1'b1;
    cyc("cancel_beats_ack", 8'd2, 1'b0, 1'b0, 8'd2);
    btn_cancel = 1'b0; choose_ack = 1'b0;
    cyc("cancel_ack_rel", 8'd2, 1'b0, 1'b0, 8'd2);
    pulse(R, "right_after_cancel", 8'd3, 8'd2);

    // Lock at 3, drop enable, button activity while idle.
    btn_confirm = 1'b1;
    cyc("confirm3", 8'd3, 1'b1, 1'b1, 8'd3);
    btn_confirm = 1'b0;
    enable = 1'b0;
    cyc("disable_locked", 8'd3, 1'b0, 1'b0, 8'd3);
    btn_right = 1'b1;
    cyc("idle_edge_dropped", 8'd3, 1'b0, 1'b0, 8'd3);
    enable = 1'b1;
    cyc("reenable_held", 8'd3, 1'b0, 1'b0, 8'd3);
    cyc("held_no_edge", 8'd3, 1'b0, 1'b0, 8'd3);
    btn_right = 1'b0;
    cyc("held_release", 8'd3, 1'b0, 1'b0, 8'd3);

    // Reset in the middle of a held repeat.
    btn_right = 1'b1;
    cyc("hold_again", 8'd4, 1'b0, 1'b0, 8'd3);
    cyc("hold_again2", 8'd4, 1'b0, 1'b0, 8'd3);
    #2 rst = 1'b1;
    #1;
    push("async_reset", 8'd1, 1'b0, 1'b0, 8'd0);
    check();
    @(posedge clk); #1;
    btn_right = 1'b0;
    rst = 1'b0;
    cyc("post_reset", 8'd1, 1'b0, 1'b0, 8'd0);
    pulse(R, "post_reset_right", 8'd2, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
